// File: rtl/aplic_direct_notifier.sv
// Direct-mode delivery engine for one APLIC interrupt domain.
// Sweeps the sources in chunks, keeps a running best (lowest priority value)
// per hart, publishes it as topi at each sweep end and serves claims.
module aplic_direct_notifier #(
  parameter int NR_SRC        = 256,
  parameter int NR_HARTS      = 5,
  parameter int PRIO_W        = 6,
  parameter int SRC_PER_CYCLE = 32,
  localparam int ID_W   = $clog2(NR_SRC),
  localparam int HART_W = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NR_SRC-1:0]            i_pending,
  input  logic [NR_SRC-1:0]            i_enabled,
  input  logic [NR_SRC*HART_W-1:0]     i_target,
  input  logic [NR_SRC*PRIO_W-1:0]     i_prio,
  input  logic [NR_HARTS-1:0]          i_idelivery,
  input  logic [NR_HARTS*PRIO_W-1:0]   i_ithreshold,
  input  logic                         i_claim_valid,
  input  logic [HART_W-1:0]            i_claim_hart,
  output logic [NR_HARTS-1:0]          o_eip,
  output logic [NR_HARTS*ID_W-1:0]     o_topi_id,
  output logic [NR_HARTS*PRIO_W-1:0]   o_topi_prio,
  output logic                         o_claim_rsp_valid,
  output logic [ID_W-1:0]              o_claim_id,
  output logic                         o_clr_valid,
  output logic [ID_W-1:0]              o_clr_id
);

  localparam int NR_CHUNKS = NR_SRC / SRC_PER_CYCLE;
  localparam int CNT_W     = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(NR_CHUNKS - 1);
  localparam logic [HART_W:0]   HART_LIMIT = (HART_W + 1)'(NR_HARTS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sweep_end;
  logic              claim_ok;
  logic [ID_W-1:0]   sel_id;

  logic [ID_W-1:0]   chunk_id   [NR_HARTS];
  logic [PRIO_W-1:0] chunk_prio [NR_HARTS];
  logic [ID_W-1:0]   acc_id_q   [NR_HARTS];
  logic [ID_W-1:0]   acc_id_d   [NR_HARTS];
  logic [PRIO_W-1:0] acc_prio_q [NR_HARTS];
  logic [PRIO_W-1:0] acc_prio_d [NR_HARTS];
  logic [ID_W-1:0]   topi_id_q  [NR_HARTS];
  logic [ID_W-1:0]   topi_id_d  [NR_HARTS];
  logic [PRIO_W-1:0] topi_prio_q[NR_HARTS];
  logic [PRIO_W-1:0] topi_prio_d[NR_HARTS];
  logic [NR_HARTS-1:0] dirty_q, dirty_d;

  logic              claim_rsp_valid_q, claim_rsp_valid_d;
  logic [ID_W-1:0]   claim_id_q, claim_id_d;
  logic              clr_valid_q, clr_valid_d;
  logic [ID_W-1:0]   clr_id_q, clr_id_d;

  // Chunk comparator: lowest eligible priority per hart, ties to the lowest ID
  always_comb begin
    logic [PRIO_W-1:0] thr;
    logic [PRIO_W-1:0] p;
    logic [HART_W-1:0] tgt;
    logic              elig;
    int                sidx;
    thr  = '0;
    p    = '0;
    tgt  = '0;
    elig = 1'b0;
    sidx = 0;
    for (int h = 0; h < NR_HARTS; h++) begin
      chunk_id[h]   = '0;
      chunk_prio[h] = '0;
      thr = i_ithreshold[h*PRIO_W +: PRIO_W];
      for (int j = 0; j < SRC_PER_CYCLE; j++) begin
        sidx = int'(cnt_q) * SRC_PER_CYCLE + j;
        p    = i_prio[sidx*PRIO_W +: PRIO_W];
        tgt  = i_target[sidx*HART_W +: HART_W];
        elig = i_pending[sidx] & i_enabled[sidx] & (sidx != 0) & (p != '0) &
               (tgt == HART_W'(h)) & ((thr == '0) | (p < thr));
        if (elig && ((chunk_id[h] == '0) || (p < chunk_prio[h]))) begin
          chunk_id[h]   = ID_W'(sidx);
          chunk_prio[h] = p;
        end
      end
    end
  end

  // Accumulator merge: chunk 0 restarts the sweep, later chunks win only on strictly lower prio
  always_comb begin
    for (int h = 0; h < NR_HARTS; h++) begin
      acc_id_d[h]   = acc_id_q[h];
      acc_prio_d[h] = acc_prio_q[h];
      if ((cnt_q == '0) ||
          ((chunk_id[h] != '0) &&
           ((acc_id_q[h] == '0) || (chunk_prio[h] < acc_prio_q[h])))) begin
        acc_id_d[h]   = chunk_id[h];
        acc_prio_d[h] = chunk_prio[h];
      end
    end
  end

  // Sweep counter, topi publication, dirty tracking and claim response
  always_comb begin
    sweep_end = (cnt_q == LAST_CHUNK);
    cnt_d     = sweep_end ? '0 : cnt_q + CNT_W'(1);
    claim_ok  = i_claim_valid && ({1'b0, i_claim_hart} < HART_LIMIT);
    sel_id    = '0;
    dirty_d   = dirty_q;
    for (int h = 0; h < NR_HARTS; h++) begin
      topi_id_d[h]   = topi_id_q[h];
      topi_prio_d[h] = topi_prio_q[h];
      if (i_claim_hart == HART_W'(h)) sel_id = topi_id_q[h];
    end
    if (sweep_end) begin
      for (int h = 0; h < NR_HARTS; h++) begin
        if (!dirty_q[h]) begin
          topi_id_d[h]   = acc_id_d[h];
          topi_prio_d[h] = acc_prio_d[h];
        end
      end
      dirty_d = '0;
    end
    // A claim overrides the sweep result and keeps the hart dirty so the
    // sweep that still sees the old pending bit cannot re-present the ID.
    for (int h = 0; h < NR_HARTS; h++) begin
      if (claim_ok && (i_claim_hart == HART_W'(h))) begin
        topi_id_d[h]   = '0;
        topi_prio_d[h] = '0;
        dirty_d[h]     = 1'b1;
      end
    end
    claim_rsp_valid_d = i_claim_valid;
    claim_id_d        = i_claim_valid ? sel_id : '0;
    clr_valid_d       = i_claim_valid && (sel_id != '0);
    clr_id_d          = clr_valid_d ? sel_id : '0;
  end

  // State registers with synchronous reset; a claim during reset is dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q             <= '0;
      dirty_q           <= '0;
      claim_rsp_valid_q <= 1'b0;
      claim_id_q        <= '0;
      clr_valid_q       <= 1'b0;
      clr_id_q          <= '0;
      for (int h = 0; h < NR_HARTS; h++) begin
        acc_id_q[h]    <= '0;
        acc_prio_q[h]  <= '0;
        topi_id_q[h]   <= '0;
        topi_prio_q[h] <= '0;
      end
    end else begin
      cnt_q             <= cnt_d;
      dirty_q           <= dirty_d;
      claim_rsp_valid_q <= claim_rsp_valid_d;
      claim_id_q        <= claim_id_d;
      clr_valid_q       <= clr_valid_d;
      clr_id_q          <= clr_id_d;
      for (int h = 0; h < NR_HARTS; h++) begin
        acc_id_q[h]    <= acc_id_d[h];
        acc_prio_q[h]  <= acc_prio_d[h];
        topi_id_q[h]   <= topi_id_d[h];
        topi_prio_q[h] <= topi_prio_d[h];
      end
    end
  end

  // Output flattening and eip gating
  always_comb begin
    o_eip       = '0;
    o_topi_id   = '0;
    o_topi_prio = '0;
    for (int h = 0; h < NR_HARTS; h++) begin
      o_eip[h]                          = i_idelivery[h] & (topi_id_q[h] != '0);
      o_topi_id[h*ID_W +: ID_W]         = topi_id_q[h];
      o_topi_prio[h*PRIO_W +: PRIO_W]   = topi_prio_q[h];
    end
  end

  assign o_claim_rsp_valid = claim_rsp_valid_q;
  assign o_claim_id        = claim_id_q;
  assign o_clr_valid       = clr_valid_q;
  assign o_clr_id          = clr_id_q;

endmodule

// File: doc/aplic_direct_notifier.md
# aplic_direct_notifier

Parametrised direct-mode delivery engine for one APLIC interrupt domain. It sweeps all interrupt sources in fixed-size chunks and keeps a registered best (lowest priority value) pending-and-enabled source per hart, gated by that hart's threshold. From that it drives each hart's external-interrupt line and `topi`, and serves claim requests. It sits between the APLIC source/register file and the hart interrupt inputs. It generalises the fixed source/hart/priority configuration to arbitrary counts with configurable scan parallelism.

## Interface
- `NR_SRC`, 256: number of sources including reserved ID 0; power of two.
- `NR_HARTS`, 5: harts served by this domain.
- `PRIO_W`, 6: priority field width.
- `SRC_PER_CYCLE`, 32: sources examined per cycle; power of two, divides `NR_SRC`. Derived values: `NR_CHUNKS = NR_SRC/SRC_PER_CYCLE`, `ID_W = $clog2(NR_SRC)`, `HART_W = max(1,$clog2(NR_HARTS))`.
- `i_clk` in 1: clock; the only clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_pending` in `NR_SRC`: source pending bits.
- `i_enabled` in `NR_SRC`: source enable bits.
- `i_target` in `NR_SRC*HART_W`: target hart index per source.
- `i_prio` in `NR_SRC*PRIO_W`: priority per source.
- `i_idelivery` in `NR_HARTS`: per-hart delivery enable.
- `i_ithreshold` in `NR_HARTS*PRIO_W`: per-hart threshold.
- `i_claim_valid` in 1: claim request strobe.
- `i_claim_hart` in `HART_W`: hart issuing the claim.
- `o_eip` out `NR_HARTS`: external interrupt pending per hart.
- `o_topi_id` out `NR_HARTS*ID_W`: best source ID per hart; 0 means none.
- `o_topi_prio` out `NR_HARTS*PRIO_W`: priority of that source.
- `o_claim_rsp_valid` out 1: claim response strobe.
- `o_claim_id` out `ID_W`: claimed ID; 0 means nothing claimed.
- `o_clr_valid` out 1: request the register file to clear pending for `o_clr_id`.
- `o_clr_id` out `ID_W`: source whose pending bit is to be cleared.

## Operation
- Eligibility of source s: `pending & enabled & s!=0 & prio!=0 & target<NR_HARTS`, and the threshold test passes. The threshold test is `ithreshold==0 | prio<ithreshold`, using the target hart's threshold.
- Chunk comparator: for each hart, pick the eligible source in the current chunk with the lowest prio. Ties go to the lowest ID.
- Per-hart accumulator (`acc_id`, `acc_prio`):
  - At chunk 0 the accumulator loads the chunk result.
  - At later chunks it is replaced only if the chunk result has a strictly lower prio, so ties keep the lower ID.
- Chunk counter runs 0..`NR_CHUNKS-1` and wraps to 0 continuously. It never stalls.
- At the end of the sweep (counter = `NR_CHUNKS-1`), the final per-hart result is registered into `topi` for every hart whose dirty flag is clear. Dirty flags clear on the same edge.
- `o_eip[h] = i_idelivery[h] & (topi_id[h]!=0)`, combinational from registered `topi`.
- Claim, when `i_claim_valid` with hart h (h<`NR_HARTS`), takes effect on the next cycle:
  - `o_claim_rsp_valid`=1 and `o_claim_id`=`topi_id[h]`.
  - If that ID is nonzero, `o_clr_valid`=1 and `o_clr_id`=same ID.
  - `topi[h]` clears to 0 and `dirty[h]` sets.
- Claim from a hart index ≥ `NR_HARTS`: respond with ID 0 and no clear.
- A claim coinciding with the sweep-end edge has priority: `topi[h]` goes to 0 and the sweep result for h is dropped.
- A claimed ID is never re-presented before the register file has acted on the clear.
- Inputs changing mid-sweep: chunks already scanned use the old values. The next sweep corrects them.

## Timing
- Reset (synchronous, active-high) sets:
  - counter=0, all accumulators/`topi`=0, all dirty=0.
  - `o_eip`=0, `o_claim_rsp_valid`=0, `o_claim_id`=0, `o_clr_valid`=0, `o_clr_id`=0.
- A claim strobed during reset is dropped.
- Sweep period is `NR_CHUNKS` cycles. `topi` updates on the edge that ends chunk `NR_CHUNKS-1`.
- Worst-case latency from an input change to `o_eip` is `2*NR_CHUNKS` cycles. After a claim, `topi[h]` is 0 for at least one full sweep and at most two.
- `o_claim_rsp_valid` and `o_clr_valid` are single-cycle pulses one cycle after the request.
- Back-to-back claims are each answered. A second claim on the same hart returns 0 until `topi` is refreshed.

## Test plan
- Reset, then idle: all outputs 0 and counter wraps every 8 cycles (defaults) -> `o_eip`=0 throughout.
- Source 40 (prio 3, hart 2) and source 10 (prio 3, hart 2), both pending and enabled, `idelivery[2]`=1 -> `topi_id[2]`=10, `prio`=3, `o_eip[2]`=1 within 16 cycles; other harts 0.
- Threshold: source 7 at prio 5 with `ithreshold[1]`=5 -> no eip. Set threshold 6 -> `topi_id[1]`=7. Set threshold 0 -> still 7.
- Claim hart 2 with `topi_id`=10 -> next cycle `o_claim_id`=10, `o_clr_valid`=1, `o_clr_id`=10. Bench clears pending[10] -> `topi_id[2]` becomes 40 within 2 sweeps.
- Claim on the exact sweep-end cycle: `topi` refreshed result is dropped, `topi_id`=0 for the following sweep, no duplicate 10 presented.
- Source 0, prio-0 source and target=7 (≥`NR_HARTS`) all pending and enabled -> never appear in `topi`. Claim from hart 6 -> `o_claim_id`=0, no clear.
